// File: rtl/vend_pkg.sv
// Shared coin codes, price, FSM states and coin valuation for the vending controller.
package vend_pkg;

    localparam int unsigned ID_W    = 2;
    localparam int unsigned PRICE_Q = 4;

    localparam logic [1:0] COIN_25   = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;
    localparam logic [1:0] COIN_NONE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        READY,
        DISPENSE,
        CHANGE,
        REFUND,
        CLEAR
    } state_t;

    // Value of a coin code in quarter-rupee units; no coin is worth nothing.
    function automatic logic [2:0] coin_quarters(input logic [1:0] code);
        logic [2:0] q;
        case (code)
            COIN_25:  q = 3'd1;
            COIN_50:  q = 3'd2;
            COIN_100: q = 3'd4;
            default:  q = 3'd0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with reload, restock-to-full, decrement and zero-flag read.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init_en,
    input  logic            dec_en,
    input  logic [ID_W-1:0] dec_id,
    input  logic            restock_en,
    input  logic [ID_W-1:0] restock_id,
    input  logic [ID_W-1:0] rd_id,
    output logic            rd_zero
);

    logic [STOCK_W-1:0] stock_q [NUM_PROD];
    logic [STOCK_W-1:0] stock_d [NUM_PROD];

    // Next stock: reload wins, then restock, then a guarded decrement.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            stock_d[i] = stock_q[i];
            if (init_en) begin
                stock_d[i] = STOCK_W'(INIT_STOCK);
            end else if (restock_en && restock_id == ID_W'(i)) begin
                stock_d[i] = '1;
            end else if (dec_en && dec_id == ID_W'(i) && stock_q[i] != '0) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    // Zero-flag read; an id beyond the product range reads as empty.
    always_comb begin
        rd_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (rd_id == ID_W'(i)) begin
                rd_zero = (stock_q[i] == '0);
            end
        end
    end

    // Stock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            stock_q <= stock_d;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: gates coins into coincol, tracks credit, runs the dispense
// handshake, issues change or refund and clears the collector.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned NUM_PROD   = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 5,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin_in,
    output logic [1:0] coin_out,
    output logic       col_rst,
    input  logic       col_done,
    output logic       coin_reject,
    input  logic       cancel,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    output logic       sold_out,
    output logic       disp_req,
    output logic [1:0] disp_id,
    input  logic       disp_ack,
    output logic       change_valid,
    output logic [2:0] change_q,
    input  logic       restock_valid,
    input  logic [1:0] restock_id,
    output logic       busy
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [2:0]       credit_q, credit_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       disp_id_q, disp_id_d;
    logic             disp_req_q, disp_req_d;
    logic             sold_out_q, sold_out_d;
    logic             change_valid_q, change_valid_d;
    logic [2:0]       chg_amt_q, chg_amt_d;
    logic             col_rst_q, col_rst_d;
    logic             busy_q, busy_d;

    logic gate_open;
    logic coin_acc;
    logic timer_exp;
    logic sel_zero;
    logic dec_en;
    logic restock_en;

    // Coin gate; coin_out is forced idle while reset is held so coincol sees no coin.
    always_comb begin
        gate_open   = (state_q == IDLE || state_q == COLLECT) && !col_done;
        coin_acc    = gate_open && coin_in != COIN_NONE;
        coin_out    = (reset && gate_open) ? coin_in : COIN_NONE;
        coin_reject = reset && !gate_open && coin_in != COIN_NONE;
        timer_exp   = (timer_q == TMR_W'(TIMEOUT));
        restock_en  = restock_valid && state_q == IDLE;
    end

    // Next-state logic and the decrement strobe for the stock bank.
    always_comb begin
        state_d    = state_q;
        disp_id_d  = disp_id_q;
        sold_out_d = 1'b0;
        dec_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_acc) state_d = COLLECT;
            end
            COLLECT: begin
                if (col_done)                 state_d = READY;
                else if (cancel || timer_exp) state_d = REFUND;
            end
            READY: begin
                if (cancel || timer_exp) begin
                    state_d = REFUND;
                end else if (sel_valid) begin
                    if (sel_zero) begin
                        sold_out_d = 1'b1;
                    end else begin
                        state_d   = DISPENSE;
                        disp_id_d = sel_id;
                    end
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    dec_en  = 1'b1;
                    state_d = (credit_q > 3'(PRICE_Q)) ? CHANGE : CLEAR;
                end
            end
            CHANGE:  state_d = CLEAR;
            REFUND:  state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit and inactivity timer.
    always_comb begin
        credit_d = credit_q;
        if (state_q == CLEAR) begin
            credit_d = '0;
        end else if (coin_acc) begin
            credit_d = credit_q + coin_quarters(coin_in);
        end

        timer_d = timer_q;
        if (((state_d == COLLECT || state_d == READY) && state_d != state_q) || coin_acc) begin
            timer_d = '0;
        end else if ((state_q == COLLECT || state_q == READY) && !timer_exp) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Registered outputs are decoded from the state being entered so they line up with it.
    always_comb begin
        disp_req_d     = (state_d == DISPENSE);
        col_rst_d      = (state_d == CLEAR);
        busy_d         = (state_d != IDLE);
        change_valid_d = (state_d == CHANGE) || (state_d == REFUND && credit_d != '0);
        chg_amt_d      = '0;
        if (state_d == CHANGE)      chg_amt_d = credit_d - 3'(PRICE_Q);
        else if (state_d == REFUND) chg_amt_d = credit_d;
    end

    // State, credit, timer and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            timer_q        <= '0;
            disp_id_q      <= '0;
            disp_req_q     <= 1'b0;
            sold_out_q     <= 1'b0;
            change_valid_q <= 1'b0;
            chg_amt_q      <= '0;
            col_rst_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            disp_id_q      <= disp_id_d;
            disp_req_q     <= disp_req_d;
            sold_out_q     <= sold_out_d;
            change_valid_q <= change_valid_d;
            chg_amt_q      <= chg_amt_d;
            col_rst_q      <= col_rst_d;
            busy_q         <= busy_d;
        end
    end

    // Holding reset low must also hold the collector in reset.
    assign col_rst      = col_rst_q | ~reset;
    assign disp_req     = disp_req_q;
    assign disp_id      = disp_id_q;
    assign sold_out     = sold_out_q;
    assign change_valid = change_valid_q;
    assign change_q     = chg_amt_q;
    assign busy         = busy_q;

    // The reload port is not needed: reset already restores the initial stock.
    vend_stock_bank #(
        .NUM_PROD   (NUM_PROD),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk        (clock),
        .rst_n      (reset),
        .init_en    (1'b0),
        .dec_en     (dec_en),
        .dec_id     (disp_id_q),
        .restock_en (restock_en),
        .restock_id (restock_id),
        .rd_id      (sel_id),
        .rd_zero    (sel_zero)
    );

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a behavioural coincol model.
module tb_vend_ctrl;

    localparam int unsigned T_OUT = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin_in;
    logic [1:0] coin_out;
    logic       col_rst;
    logic       col_done;
    logic       coin_reject;
    logic       cancel;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       sold_out;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       disp_ack;
    logic       change_valid;
    logic [2:0] change_q;
    logic       restock_valid;
    logic [1:0] restock_id;
    logic       busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    vend_ctrl #(
        .NUM_PROD   (3),
        .STOCK_W    (4),
        .INIT_STOCK (5),
        .TIMEOUT    (T_OUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .coin_in       (coin_in),
        .coin_out      (coin_out),
        .col_rst       (col_rst),
        .col_done      (col_done),
        .coin_reject   (coin_reject),
        .cancel        (cancel),
        .sel_valid     (sel_valid),
        .sel_id        (sel_id),
        .sold_out      (sold_out),
        .disp_req      (disp_req),
        .disp_id       (disp_id),
        .disp_ack      (disp_ack),
        .change_valid  (change_valid),
        .change_q      (change_q),
        .restock_valid (restock_valid),
        .restock_id    (restock_id),
        .busy          (busy)
    );

    // coincol model: registered total in quarters, done once 100p is reached.
    logic [3:0] col_tot = '0;
    assign col_done = (col_tot >= 4'd4);

    always @(posedge clock) begin
        if (col_rst) begin
            col_tot <= '0;
        end else begin
            case (coin_out)
                2'b00:   col_tot <= col_tot + 4'd1;
                2'b01:   col_tot <= col_tot + 4'd2;
                2'b10:   col_tot <= col_tot + 4'd4;
                default: col_tot <= col_tot;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_in = c;
        #1;
        check("coin_pass", 32'(coin_out), 32'(c));
        check("coin_norej", 32'(coin_reject), 0);
        tick();
        coin_in = 2'b11;
    endtask

    // One 100p purchase of product id with no change.
    task automatic buy(input logic [1:0] id);
        put_coin(2'b10);
        tick();
        sel_id    = id;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("buy_req", 32'(disp_req), 1);
        check("buy_id", 32'(disp_id), 32'(id));
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check("buy_req_drop", 32'(disp_req), 0);
        check("buy_nochg", 32'(change_valid), 0);
        check("buy_col_rst", 32'(col_rst), 1);
        tick();
        check("buy_idle", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        coin_in = 2'b00; cancel = 1'b0; sel_valid = 1'b0; sel_id = 2'd0;
        disp_ack = 1'b0; restock_valid = 1'b0; restock_id = 2'd0;

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        check("rst_coin_out", 32'(coin_out), 3);
        check("rst_col_rst", 32'(col_rst), 1);
        check("rst_reject", 32'(coin_reject), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(disp_req), 0);
        check("rst_chg", 32'(change_valid), 0);
        check("rst_chg_q", 32'(change_q), 0);
        check("rst_sold", 32'(sold_out), 0);
        check("rst_stock1", 32'(dut.u_stock.stock_q[1]), 5);
        coin_in = 2'b11;
        reset   = 1'b1;
        #1;
        check("rel_col_rst", 32'(col_rst), 0);
        tick();

        // Four 25p coins, select 0, ack in third DISPENSE cycle.
        for (int i = 0; i < 4; i++) put_coin(2'b00);
        check("t1_busy", 32'(busy), 1);
        tick();
        sel_id = 2'd0; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("t1_req0", 32'(disp_req), 1);
        check("t1_id", 32'(disp_id), 0);
        tick();
        check("t1_req1", 32'(disp_req), 1);
        tick();
        check("t1_req2", 32'(disp_req), 1);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check("t1_req_drop", 32'(disp_req), 0);
        check("t1_nochg", 32'(change_valid), 0);
        check("t1_col_rst", 32'(col_rst), 1);
        check("t1_stock0", 32'(dut.u_stock.stock_q[0]), 4);
        tick();
        check("t1_col_rst_end", 32'(col_rst), 0);
        check("t1_idle", 32'(busy), 0);

        // 75p then 100p: credit 7, change of 3.
        put_coin(2'b00);
        put_coin(2'b01);
        put_coin(2'b10);
        tick();
        sel_id = 2'd1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        disp_ack  = 1'b1;
        tick();
        disp_ack  = 1'b0;
        check("t2_chg_v", 32'(change_valid), 1);
        check("t2_chg_q", 32'(change_q), 3);
        check("t2_req_drop", 32'(disp_req), 0);
        tick();
        check("t2_chg_pulse", 32'(change_valid), 0);
        check("t2_col_rst", 32'(col_rst), 1);
        tick();
        check("t2_idle", 32'(busy), 0);

        // 50p then cancel: refund 2.
        put_coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t3_chg_v", 32'(change_valid), 1);
        check("t3_chg_q", 32'(change_q), 2);
        tick();
        check("t3_col_rst", 32'(col_rst), 1);
        tick();
        check("t3_idle", 32'(busy), 0);

        // Gate closes once col_done is up, and stays closed in READY.
        put_coin(2'b10);
        coin_in = 2'b01;
        #1;
        check("t3_gate_done_out", 32'(coin_out), 3);
        check("t3_gate_done_rej", 32'(coin_reject), 1);
        tick();
        coin_in = 2'b00;
        #1;
        check("t3_ready_out", 32'(coin_out), 3);
        check("t3_ready_rej", 32'(coin_reject), 1);
        coin_in = 2'b11;
        #1;
        check("t3_ready_norej", 32'(coin_reject), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t3_refund4_v", 32'(change_valid), 1);
        check("t3_refund4_q", 32'(change_q), 4);
        repeat (2) tick();

        // Drain product 2, then sold-out and invalid-id selections.
        for (int i = 0; i < 5; i++) buy(2'd2);
        check("t4_stock2_zero", 32'(dut.u_stock.stock_q[2]), 0);
        put_coin(2'b10);
        tick();
        sel_id = 2'd2; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("t4_sold", 32'(sold_out), 1);
        check("t4_sold_noreq", 32'(disp_req), 0);
        check("t4_sold_busy", 32'(busy), 1);
        tick();
        check("t4_sold_pulse", 32'(sold_out), 0);
        sel_id = 2'd3; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("t4_badid_sold", 32'(sold_out), 1);
        check("t4_badid_noreq", 32'(disp_req), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t4_refund_q", 32'(change_q), 4);
        repeat (2) tick();
        check("t4_idle", 32'(busy), 0);
        restock_id = 2'd2; restock_valid = 1'b1;
        tick();
        restock_valid = 1'b0;
        check("t4_restock2", 32'(dut.u_stock.stock_q[2]), 15);
        put_coin(2'b00);
        restock_id = 2'd0; restock_valid = 1'b1;
        tick();
        restock_valid = 1'b0;
        check("t4_restock_busy_ign", 32'(dut.u_stock.stock_q[0]), 4);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        repeat (2) tick();
        buy(2'd2);
        check("t4_stock2_after", 32'(dut.u_stock.stock_q[2]), 14);

        // 25p then idle until the timer refunds it.
        put_coin(2'b00);
        n = 0;
        for (int k = 1; k <= int'(T_OUT) + 5; k++) begin
            tick();
            if (change_valid) begin
                n = k;
                break;
            end
        end
        check("t5_timeout_cycle", 32'(n), T_OUT + 1);
        check("t5_chg_q", 32'(change_q), 1);
        tick();
        check("t5_col_rst", 32'(col_rst), 1);
        tick();
        check("t5_idle", 32'(busy), 0);

        // Reset during DISPENSE.
        put_coin(2'b10);
        tick();
        sel_id = 2'd1; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("t6_req", 32'(disp_req), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_req_async", 32'(disp_req), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_col_rst", 32'(col_rst), 1);
        check("t6_stock0", 32'(dut.u_stock.stock_q[0]), 5);
        check("t6_stock2", 32'(dut.u_stock.stock_q[2]), 5);
        coin_in = 2'b00;
        #1;
        check("t6_coin_out", 32'(coin_out), 3);
        check("t6_norej", 32'(coin_reject), 0);
        coin_in = 2'b11;
        repeat (2) tick();
        check("t6_nochg", 32'(change_valid), 0);
        check("t6_stock1", 32'(dut.u_stock.stock_q[1]), 5);
        reset = 1'b1;
        tick();
        put_coin(2'b00);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t6_credit_cleared", 32'(change_q), 1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
